secuenciador_suma: RTL and testbench



---
 rtl/secuenciador_suma_pkg.sv | 18 +
 rtl/secuenciador_suma_if.sv | 32 +++
 rtl/secuenciador_suma_sum_rizado.sv | 39 +++
 rtl/secuenciador_suma.sv | 126 ++++++++++++
 tb/tb_secuenciador_suma.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/secuenciador_suma_pkg.sv
// Shared definitions for the multi-word add/subtract sequencer:
// FSM encodings, word width and the one-bit full-adder cell.
package secuenciador_suma_pkg;

  localparam int PAL_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SUMA = 2'b01,
    FIN  = 2'b10
  } estado_e;

  // Returns {carry_out, sum} of a single-bit full adder.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
    full_add = {(x & y) | (c & (x ^ y)), x ^ y ^ c};
  endfunction

endpackage

// File: rtl/secuenciador_suma_if.sv
// Operand/result handshake bundle between the operand source, the sequencer
// and the result consumer.
interface secuenciador_suma_if
  import secuenciador_suma_pkg::*;
#(
  parameter int NPAL = 4
) ();

  localparam int W = PAL_W * NPAL;

  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ci;
  logic         busy;
  logic         done;
  logic [W-1:0] s;
  logic         co;
  logic         ov;

  modport master (
    output start, sub, a, b, ci,
    input  busy, done, s, co, ov
  );

  modport slave (
    input  start, sub, a, b, ci,
    output busy, done, s, co, ov
  );

endinterface

// File: rtl/secuenciador_suma_sum_rizado.sv
// SUM_RIZADO: combinational 8-bit ripple-carry adder shared by the sequencer.
// A non-zero PwrC isolates the operands while the adder is not in use.
module secuenciador_suma_sum_rizado
  import secuenciador_suma_pkg::*;
#(
  parameter int PwrC = 0
) (
  input  logic             en,
  input  logic [PAL_W-1:0] a,
  input  logic [PAL_W-1:0] b,
  input  logic             ci,
  output logic [PAL_W-1:0] s,
  output logic             co
);

  logic             iso_s;
  logic [PAL_W-1:0] a_g_s;
  logic [PAL_W-1:0] b_g_s;
  logic [PAL_W:0]   c_s;
  logic [1:0]       fa_s;

  // Operand isolation followed by the bit-serial carry chain.
  always_comb begin
    iso_s = (PwrC != 0) ? en : 1'b1;
    a_g_s = a & {PAL_W{iso_s}};
    b_g_s = b & {PAL_W{iso_s}};
    c_s   = {(PAL_W + 1){1'b0}};
    s     = {PAL_W{1'b0}};
    fa_s  = 2'b00;
    c_s[0] = ci & iso_s;
    for (int i = 0; i < PAL_W; i++) begin
      fa_s       = full_add(a_g_s[i], b_g_s[i], c_s[i]);
      s[i]       = fa_s[0];
      c_s[i + 1] = fa_s[1];
    end
    co = c_s[PAL_W];
  end

endmodule

// File: rtl/secuenciador_suma.sv
// Multi-word add/subtract sequencer: one byte per clock, LSB first, through a
// single shared 8-bit ripple adder with a registered inter-word carry.
module secuenciador_suma
  import secuenciador_suma_pkg::*;
#(
  parameter int NPAL = 4,
  parameter int PwrC = 0
) (
  input  logic                clk,
  input  logic                rst,
  secuenciador_suma_if.slave  bus
);

  localparam int W  = PAL_W * NPAL;
  localparam int KW = $clog2(NPAL);

  estado_e                      state_q, state_d;
  logic [KW-1:0]                k_q, k_d;
  logic [NPAL-1:0][PAL_W-1:0]   a_q, a_d;
  logic [NPAL-1:0][PAL_W-1:0]   b_q, b_d;
  logic [NPAL-1:0][PAL_W-1:0]   s_q, s_d;
  logic                         carry_q, carry_d;
  logic                         co_q, co_d;
  logic                         ov_q, ov_d;
  logic                         busy_q, busy_d;
  logic                         done_q, done_d;

  logic                         en_s;
  logic [PAL_W-1:0]             sum_s;
  logic                         cout_s;

  secuenciador_suma_sum_rizado #(
    .PwrC (PwrC)
  ) u_sum_rizado (
    .en (en_s),
    .a  (a_q[k_q]),
    .b  (b_q[k_q]),
    .ci (carry_q),
    .s  (sum_s),
    .co (cout_s)
  );

  // Next-state, word sequencing and result update.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    carry_d = carry_q;
    co_d    = co_q;
    ov_d    = ov_q;
    busy_d  = (state_q != IDLE);
    done_d  = (state_q == FIN);
    en_s    = 1'b0;

    case (state_q)
      IDLE: begin
        // done_q still high means the result is being consumed this cycle.
        if (bus.start && !done_q) begin
          state_d = SUMA;
          k_d     = {KW{1'b0}};
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? 1'b1 : bus.ci;
        end else begin
          state_d = IDLE;
        end
      end
      SUMA: begin
        en_s       = 1'b1;
        s_d[k_q]   = sum_s;
        carry_d    = cout_s;
        if (k_q == KW'(NPAL - 1)) begin
          state_d = FIN;
          k_d     = {KW{1'b0}};
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      FIN: begin
        co_d    = carry_q;
        ov_d    = (a_q[NPAL-1][PAL_W-1] == b_q[NPAL-1][PAL_W-1]) &&
                  (s_q[NPAL-1][PAL_W-1] != a_q[NPAL-1][PAL_W-1]);
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= {KW{1'b0}};
      a_q     <= {W{1'b0}};
      b_q     <= {W{1'b0}};
      s_q     <= {W{1'b0}};
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      co_q    <= co_d;
      ov_q    <= ov_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.s    = s_q;
  assign bus.co   = co_q;
  assign bus.ov   = ov_q;

endmodule

// File: tb/tb_secuenciador_suma.sv
// Directed scoreboard bench for secuenciador_suma with NPAL=4.
module tb_secuenciador_suma;

  typedef struct packed {
    logic [31:0] s;
    logic        co;
    logic        ov;
  } exp_t;

  logic clk;
  logic rst;
  int   ntests;
  int   nfail;
  exp_t sb_q[$];

  secuenciador_suma_if #(.NPAL(4)) bus ();

  secuenciador_suma #(
    .NPAL (4),
    .PwrC (0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] av, input logic [31:0] bv,
                                 input logic sv, input logic civ);
    exp_t        m;
    logic [31:0] bp;
    logic [32:0] r;
    bp   = sv ? ~bv : bv;
    r    = {1'b0, av} + {1'b0, bp} + {32'd0, (sv ? 1'b1 : civ)};
    m.s  = r[31:0];
    m.co = r[32];
    m.ov = (av[31] == bp[31]) && (r[31] != av[31]);
    return m;
  endfunction

  task automatic sb_check(input string tag);
    exp_t e;
    ntests++;
    assert (sb_q.size() > 0) else begin
      nfail++;
      $error("FAIL %s_sb: observed done with empty scoreboard, expected no done", tag);
    end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({tag, "_s"},  bus.s,  e.s);
      chk({tag, "_co"}, {31'd0, bus.co}, {31'd0, e.co});
      chk({tag, "_ov"}, {31'd0, bus.ov}, {31'd0, e.ov});
    end
  endtask

  task automatic drive(input logic [31:0] av, input logic [31:0] bv,
                       input logic sv, input logic civ);
    bus.a   = av;
    bus.b   = bv;
    bus.sub = sv;
    bus.ci  = civ;
  endtask

  // One operation from idle: checks result, done latency and busy length.
  task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input logic sv, input logic civ);
    int lat;
    int nbusy;
    bit seen;
    @(negedge clk);
    bus.start = 1'b1;
    drive(av, bv, sv, civ);
    sb_q.push_back(model(av, bv, sv, civ));
    lat = 0; nbusy = 0; seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (bus.busy) nbusy++;
      if (bus.done) begin
        seen = 1'b1;
        sb_check(tag);
      end
      bus.start = 1'b0;
      drive($urandom, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)));
    end
    chk({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    chk({tag, "_latency"}, lat, 32'd6);
    chk({tag, "_busy_cycles"}, nbusy, 32'd5);
  endtask

  initial begin
    int   ndone;
    bit   arm;
    bit   push_now;
    bit   gotdone;
    logic [31:0] av, bv;
    logic sv, civ;

    ntests = 0;
    nfail  = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    drive(32'd0, 32'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_s",    bus.s,             32'd0);
    chk("rst_co",   {31'd0, bus.co},   32'd0);
    chk("rst_ov",   {31'd0, bus.ov},   32'd0);
    rst = 1'b0;

    run_op("add_ff_1",   32'h000000FF, 32'h00000001, 1'b0, 1'b0);
    run_op("add_ripple", 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1);
    run_op("sub_borrow", 32'h00000005, 32'h00000007, 1'b1, 1'b0);
    run_op("sub_ov",     32'h80000000, 32'h00000001, 1'b1, 1'b1);
    run_op("add_ov",     32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("hold_s",  bus.s,           32'h80000000);
    chk("hold_ov", {31'd0, bus.ov}, 32'd1);
    run_op("add_rand", 32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b1);

    // start held high with operands changing every cycle
    @(negedge clk);
    av = $urandom; bv = $urandom; sv = 1'($urandom_range(1)); civ = 1'($urandom_range(1));
    bus.start = 1'b1;
    drive(av, bv, sv, civ);
    sb_q.push_back(model(av, bv, sv, civ));
    ndone = 0; arm = 1'b0;
    for (int i = 0; i < 40 && ndone < 2; i++) begin
      @(negedge clk);
      gotdone = bus.done;
      if (gotdone) begin
        sb_check("held_start");
        ndone++;
      end
      push_now = arm;
      arm = gotdone;
      av = $urandom; bv = $urandom; sv = 1'($urandom_range(1)); civ = 1'($urandom_range(1));
      drive(av, bv, sv, civ);
      if (push_now) sb_q.push_back(model(av, bv, sv, civ));
    end
    bus.start = 1'b0;
    chk("held_ndone", ndone, 32'd2);
    chk("held_sb_empty", sb_q.size(), 32'd0);

    // reset while the third word is being added
    @(negedge clk);
    bus.start = 1'b1;
    drive(32'h01020304, 32'h10203040, 1'b0, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    chk("abort_s",    bus.s,             32'd0);
    chk("abort_co",   {31'd0, bus.co},   32'd0);
    chk("abort_ov",   {31'd0, bus.ov},   32'd0);
    gotdone = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done) gotdone = 1'b1;
    end
    chk("abort_no_done", {31'd0, gotdone}, 32'd0);
    run_op("after_abort", 32'hDEADBEEF, 32'h01234567, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
